// File: rtl/nes_focus_arbiter.sv
// rtl/nes_focus_arbiter.sv - NES controller focus arbiter for the VGA, clock and audio consumers
//
// Routes one NES controller to three front-panel consumers. Select rotates
// focus; every other button press becomes a one-cycle command pulse on the
// bus of the consumer that currently holds focus.
//
// Optional feature macro: NES_AUTOREPEAT_EN
//   defined   : a single held direction auto-repeats (HOLD/REPEAT states + counter)
//   undefined : exactly one pulse per press, no hold counter
//
// Ports:
//   clock          in   system clock (50 MHz)
//   reset_n        in   asynchronous active-low reset
//   buttons[7:0]   in   button levels {a, b, select, start, up, down, left, right}
//   owner[1:0]     out  focus holder: 0 VGA, 1 CLOCK, 2 AUDIO
//   owner_changed  out  one-cycle pulse when owner advances
//   vga_cmd[7:0]   out  command pulses for the VGA consumer (select bit always 0)
//   clk_cmd[7:0]   out  command pulses for the seven-segment clock driver
//   aud_cmd[7:0]   out  command pulses for the audio path
module nes_focus_arbiter #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] buttons,
  output logic [1:0] owner,
  output logic       owner_changed,
  output logic [7:0] vga_cmd,
  output logic [7:0] clk_cmd,
  output logic [7:0] aud_cmd
);

  localparam int         SEL_BIT   = 5;
  // Every button except select can become a command.
  localparam logic [7:0] CMD_MASK  = 8'hDF;
  localparam logic [1:0] OWNER_VGA = 2'd0;
  localparam logic [1:0] OWNER_CLK = 2'd1;
  localparam logic [1:0] OWNER_AUD = 2'd2;

  // Zero-length hold or repeat periods have no meaning; refuse to elaborate them.
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("nes_focus_arbiter: HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
  end

`ifdef NES_AUTOREPEAT_EN
  typedef enum logic [1:0] {ST_LOCK, ST_IDLE, ST_HOLD, ST_REPEAT} state_e;

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`else
  typedef enum logic [1:0] {ST_LOCK, ST_IDLE} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] prev_q;
  logic [1:0] owner_q, owner_d;
  logic       owner_changed_q, owner_changed_d;
  logic [7:0] vga_cmd_q, vga_cmd_d;
  logic [7:0] clk_cmd_q, clk_cmd_d;
  logic [7:0] aud_cmd_q, aud_cmd_d;

  logic [7:0] btn_edge;
  logic       sel_edge;
  logic [7:0] pulse;

`ifdef NES_AUTOREPEAT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rep_q, rep_d;      // one-hot direction being repeated
  logic [3:0]       dir_lvl;
  logic             dir_edge;
  logic             single_dir;

  assign dir_lvl    = buttons[3:0];
  assign dir_edge   = |btn_edge[3:0];
  // Exactly one direction held: non-zero and a power of two.
  assign single_dir = (dir_lvl != 4'd0) && ((dir_lvl & (dir_lvl - 4'd1)) == 4'd0);
`endif

  assign btn_edge = buttons & ~prev_q;
  assign sel_edge = btn_edge[SEL_BIT];

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    owner_changed_d = 1'b0;
    pulse           = 8'h00;
`ifdef NES_AUTOREPEAT_EN
    cnt_d           = cnt_q;
    rep_d           = rep_q;
`endif

    if (sel_edge) begin
      // Focus change wins over everything else seen this cycle; LOCK then
      // keeps buttons still held from leaking to the new owner.
      case (owner_q)
        OWNER_VGA: owner_d = OWNER_CLK;
        OWNER_CLK: owner_d = OWNER_AUD;
        default:   owner_d = OWNER_VGA;
      endcase
      owner_changed_d = 1'b1;
      state_d         = ST_LOCK;
`ifdef NES_AUTOREPEAT_EN
      cnt_d           = '0;
`endif
    end else begin
      case (state_q)
        ST_LOCK: begin
          if ((buttons & CMD_MASK) == 8'h00) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          pulse = btn_edge & CMD_MASK;
`ifdef NES_AUTOREPEAT_EN
          if (dir_edge) begin
            // Any new direction press restarts repeat tracking; chords never repeat.
            cnt_d = '0;
            if (single_dir) begin
              state_d = ST_HOLD;
              rep_d   = dir_lvl;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (state_q == ST_HOLD || state_q == ST_REPEAT) begin
            if ((dir_lvl & rep_q) == 4'd0) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (state_q == ST_HOLD && cnt_q == HOLD_LAST) begin
              pulse   = pulse | {4'd0, rep_q};
              cnt_d   = '0;
              state_d = ST_REPEAT;
            end else if (state_q == ST_REPEAT && cnt_q == REPEAT_LAST) begin
              pulse   = pulse | {4'd0, rep_q};
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + 1'b1;
            end
          end
`endif
        end
      endcase
    end

    vga_cmd_d = (owner_q == OWNER_VGA) ? pulse : 8'h00;
    clk_cmd_d = (owner_q == OWNER_CLK) ? pulse : 8'h00;
    aud_cmd_d = (owner_q == OWNER_AUD) ? pulse : 8'h00;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_LOCK;
      // All-ones so buttons held through reset never look like a press.
      prev_q          <= 8'hFF;
      owner_q         <= OWNER_VGA;
      owner_changed_q <= 1'b0;
      vga_cmd_q       <= 8'h00;
      clk_cmd_q       <= 8'h00;
      aud_cmd_q       <= 8'h00;
`ifdef NES_AUTOREPEAT_EN
      cnt_q           <= '0;
      rep_q           <= 4'd0;
`endif
    end else begin
      state_q         <= state_d;
      prev_q          <= buttons;
      owner_q         <= owner_d;
      owner_changed_q <= owner_changed_d;
      vga_cmd_q       <= vga_cmd_d;
      clk_cmd_q       <= clk_cmd_d;
      aud_cmd_q       <= aud_cmd_d;
`ifdef NES_AUTOREPEAT_EN
      cnt_q           <= cnt_d;
      rep_q           <= rep_d;
`endif
    end
  end

  assign owner         = owner_q;
  assign owner_changed = owner_changed_q;
  assign vga_cmd       = vga_cmd_q;
  assign clk_cmd       = clk_cmd_q;
  assign aud_cmd       = aud_cmd_q;

endmodule

// File: tb/tb_nes_focus_arbiter.sv
// tb/tb_nes_focus_arbiter.sv - scoreboard bench for nes_focus_arbiter
module tb_nes_focus_arbiter;

  localparam int HOLD   = 8;
  localparam int REPEAT = 4;
`ifdef NES_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] buttons;
  logic [1:0] owner;
  logic       owner_changed;
  logic [7:0] vga_cmd, clk_cmd, aud_cmd;

  nes_focus_arbiter #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .buttons      (buttons),
    .owner        (owner),
    .owner_changed(owner_changed),
    .vga_cmd      (vga_cmd),
    .clk_cmd      (clk_cmd),
    .aud_cmd      (aud_cmd)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [1:0] owner;
    logic       chg;
    logic [7:0] vga;
    logic [7:0] clk;
    logic [7:0] aud;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: owner = select presses mod 3, a lock flag, and repeat
  // pulses derived arithmetically from the time the held direction was pressed.
  logic [7:0] m_prev;
  int         m_owner;
  bit         m_locked;
  int         m_rep;
  int         m_start;

  task automatic model_reset();
    m_prev   = 8'hFF;
    m_owner  = 0;
    m_locked = 1'b1;
    m_rep    = -1;
    m_start  = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input int t);
    logic [7:0] e;
    logic [7:0] p;
    bit         chg;
    exp_t       x;
    int         el;
    e      = b & ~m_prev;
    m_prev = b;
    p      = 8'h00;
    chg    = 1'b0;
    if (e[5]) begin
      m_owner  = (m_owner + 1) % 3;
      chg      = 1'b1;
      m_locked = 1'b1;
      m_rep    = -1;
    end else if (m_locked) begin
      if ((b & 8'hDF) == 8'h00) m_locked = 1'b0;
    end else begin
      p = e & 8'hDF;
      if (e[3:0] != 4'd0) begin
        m_rep = -1;
        if (AR && $countones(b[3:0]) == 1) begin
          for (int i = 0; i < 4; i++) if (b[i]) m_rep = i;
          m_start = t;
        end
      end else if (m_rep >= 0) begin
        el = t - m_start;
        if (!b[m_rep]) m_rep = -1;
        else if (el >= HOLD && ((el - HOLD) % REPEAT) == 0) p[m_rep] = 1'b1;
      end
    end
    if (chg || p != 8'h00) begin
      x.t     = t;
      x.owner = 2'(m_owner);
      x.chg   = chg;
      x.vga   = (m_owner == 0) ? p : 8'h00;
      x.clk   = (m_owner == 1) ? p : 8'h00;
      x.aud   = (m_owner == 2) ? p : 8'h00;
      exp_q.push_back(x);
    end
  endtask

  // Monitor: compare every DUT output event against the oldest expectation.
  exp_t e_mon;
  always @(negedge clock) begin
    if (reset_n) begin
      if (owner_changed || vga_cmd != 8'h00 || clk_cmd != 8'h00 || aud_cmd != 8'h00) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event cyc=%0d got owner=%0d chg=%b vga=%h clk=%h aud=%h, required no event",
                   cyc, owner, owner_changed, vga_cmd, clk_cmd, aud_cmd);
        end else begin
          e_mon = exp_q.pop_front();
          if (e_mon.t != cyc || e_mon.owner !== owner || e_mon.chg !== owner_changed ||
              e_mon.vga !== vga_cmd || e_mon.clk !== clk_cmd || e_mon.aud !== aud_cmd) begin
            n_fail++;
            $display("FAIL event cyc=%0d got owner=%0d chg=%b vga=%h clk=%h aud=%h, required cyc=%0d owner=%0d chg=%b vga=%h clk=%h aud=%h",
                     cyc, owner, owner_changed, vga_cmd, clk_cmd, aud_cmd,
                     e_mon.t, e_mon.owner, e_mon.chg, e_mon.vga, e_mon.clk, e_mon.aud);
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
        e_mon = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_event at cyc=%0d: got nothing, required owner=%0d chg=%b vga=%h clk=%h aud=%h",
                 e_mon.t, e_mon.owner, e_mon.chg, e_mon.vga, e_mon.clk, e_mon.aud);
      end
    end
  end

  task automatic drive_n(input logic [7:0] v, input int n);
    repeat (n) begin
      @(negedge clock);
      buttons = v;
      model_step(v, cyc + 1);
    end
  endtask

  task automatic check_quiet(input string name);
    n_tests++;
    if (owner !== 2'd0 || owner_changed !== 1'b0 || vga_cmd !== 8'h00 ||
        clk_cmd !== 8'h00 || aud_cmd !== 8'h00) begin
      n_fail++;
      $display("FAIL %s: got owner=%0d chg=%b vga=%h clk=%h aud=%h, required all 0",
               name, owner, owner_changed, vga_cmd, clk_cmd, aud_cmd);
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n = 1'b1;
    model_step(buttons, cyc + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int         r;
    int         idx;

    reset_n = 1'b0;
    buttons = 8'h08;
    model_reset();
    repeat (3) @(negedge clock);
    check_quiet("reset_state");
    reset_n = 1'b1;
    model_step(buttons, cyc + 1);

    // Up held through reset, then released and pressed again.
    drive_n(8'h08, 5);
    drive_n(8'h00, 2);
    drive_n(8'h08, 3);
    drive_n(8'h00, 3);

    // Three selects, 5 cycles apart.
    for (int i = 0; i < 3; i++) begin
      drive_n(8'h20, 1);
      drive_n(8'h00, 4);
    end

    // Owner 1: hold up for 20 cycles.
    drive_n(8'h20, 1);
    drive_n(8'h00, 3);
    drive_n(8'h08, 21);
    drive_n(8'h00, 3);

    // Back to owner 0, select while up held, then release and re-press.
    drive_n(8'h20, 1);
    drive_n(8'h00, 2);
    drive_n(8'h20, 1);
    drive_n(8'h00, 2);
    drive_n(8'h08, 10);
    drive_n(8'h28, 2);
    drive_n(8'h08, 10);
    drive_n(8'h00, 2);
    drive_n(8'h08, 2);
    drive_n(8'h00, 2);

    // Owner 2: left+right chord held 30 cycles, then a/b/start during a hold.
    drive_n(8'h20, 1);
    drive_n(8'h00, 2);
    drive_n(8'h03, 31);
    drive_n(8'h00, 2);
    drive_n(8'h04, 10);
    drive_n(8'h84, 1);
    drive_n(8'h04, 3);
    drive_n(8'h54, 2);
    drive_n(8'h04, 12);
    drive_n(8'h00, 2);

    // Randomized phase: sparse toggles so holds last long enough to repeat.
    v = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        idx = $urandom_range(0, 6);
        if (idx >= 5) idx++;
        v[idx] = ~v[idx];
      end else if (r < 8) begin
        v[5] = ~v[5];
      end else if (r == 8) begin
        v = 8'h00;
      end
      drive_n(v, 1);
    end

    // Asynchronous reset in the middle of a repeating hold.
    drive_n(8'h00, 3);
    if (m_owner == 0) begin
      drive_n(8'h20, 1);
      drive_n(8'h00, 2);
    end
    drive_n(8'h04, 15);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_quiet("async_reset_mid_hold");
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clock);
    release_reset();
    drive_n(8'h04, 12);
    drive_n(8'h00, 2);
    drive_n(8'h02, 3);
    drive_n(8'h00, 4);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations: got %0d pending, required 0", exp_q.size());
    end
    n_tests++;
    if (owner !== 2'(m_owner)) begin
      n_fail++;
      $display("FAIL final_owner: got %0d, required %0d", owner, m_owner);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
